// File: rtl/gf2m_unsquare_seq.sv
// Sequential GF(2^163) un-square/adder: result = sqrt(in_r) ^ in_b (opt=1) or in_r ^ in_b (opt=0).
// sqrt(a) = a^(2^162), computed as SQ_PER_CYC chained squarings per cycle.
module gf2m_unsquare_seq #(
    parameter int unsigned M          = 163,
    parameter int unsigned SQ_PER_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         opt,
    input  logic [M-1:0] in_r,
    input  logic [M-1:0] in_b,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] result
);

    localparam int unsigned N  = (M - 1) / SQ_PER_CYC;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQR  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [M-1:0]   acc_q, acc_d;
    logic [M-1:0]   breg_q, breg_d;
    logic           opt_q, opt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [M-1:0]   result_q, result_d;

    // a^2 mod x^163 + x^7 + x^6 + x^3 + 1: spread bits, then fold high terms down from the top
    function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
        logic [2*M-2:0] t;
        int             base;
        t = '0;
        for (int i = 0; i < int'(M); i++) begin
            t[2*i] = a[i];
        end
        for (int j = 2*int'(M) - 2; j >= int'(M); j--) begin
            if (t[j]) begin
                base        = j - int'(M);
                t[base + 7] = t[base + 7] ^ 1'b1;
                t[base + 6] = t[base + 6] ^ 1'b1;
                t[base + 3] = t[base + 3] ^ 1'b1;
                t[base]     = t[base] ^ 1'b1;
                t[j]        = 1'b0;
            end
        end
        return t[M-1:0];
    endfunction

    logic [M-1:0] sq_chain [SQ_PER_CYC+1];

    always_comb begin
        sq_chain[0] = acc_q;
        for (int k = 0; k < int'(SQ_PER_CYC); k++) begin
            sq_chain[k+1] = gf_sq(sq_chain[k]);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        breg_d   = breg_q;
        opt_d    = opt_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = in_r;
                    breg_d  = in_b;
                    opt_d   = opt;
                    cnt_d   = '0;
                    state_d = opt ? S_SQR : S_FIN;
                end
            end
            S_SQR: begin
                acc_d = sq_chain[SQ_PER_CYC];
                cnt_d = cnt_q + CW'(1);
                if (!opt_q || cnt_q == CW'(N - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                result_d = acc_q ^ breg_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            breg_q   <= '0;
            opt_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            breg_q   <= breg_d;
            opt_q    <= opt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
